coil_phase_decoder: RTL and testbench
=====================================

// Module: coil_phase_decoder
// PURPOSE
//   Receive-side monitor for the 4-bit stepper coil drive bus. Decodes wave, two-phase and half-step
//   patterns back into step events, direction, step size and a signed half-step position.
//   Flags illegal patterns and skipped phases. Sits beside the motor driver for closed-loop checks and display.
// PARAMETERS
//   POS_W            16   width of signed position counter (half-step units, two's complement)
//   QTURN_HALFSTEPS  400  half-steps per quarter turn, used for qturn_pulse; must be >= 1
//   DEGLITCH_CYCLES  3    consecutive equal samples needed to accept a pattern (COIL_DEGLITCH_EN only); >= 1
// PORTS
//   clk         in   1      system clock; all logic on rising edge
//   rst         in   1      asynchronous, active-high reset
//   coil_in     in   4      coil drive pattern, synchronous to clk
//   zero_pos    in   1      1-cycle strobe: clear position and quarter-turn counter
//   err_clear   in   1      1-cycle strobe: leave ERROR state
//   step_pulse  out  1      1-cycle pulse per decoded step
//   step_dir    out  1      direction of last step (1 = forward / increasing phase)
//   step_half   out  1      last step was a half-step (phase delta +/-1)
//   position    out  POS_W  signed half-step position
//   qturn_pulse out  1      1-cycle pulse every QTURN_HALFSTEPS half-steps moved in one direction
//   idle        out  1      decoder is in IDLE (coils off or no reference phase)
//   error       out  1      sticky error, high while in ERROR
// BEHAVIOUR
//   Reset: all outputs 0, idle=1, state IDLE, reference phase 0, internal counters 0.
//   Phase map (index 0..7): 0001,0011,0010,0110,0100,1100,1000,1001. 0000 = OFF. Any other code = ILLEGAL.
//   Pipeline: coil_in is registered into coil_q. Decode compares coil_q with the reference phase.
//     Outputs update on the 2nd rising edge after coil_in changes, plus DEGLITCH_CYCLES when filtered.
//   delta = (new_idx - ref_idx) mod 8. Decoding of delta:
//     0   -> no event
//     1   -> fwd half; 2 -> fwd full
//     7   -> rev half; 6 -> rev full
//     3,4,5 -> skip error
//   FSM states:
//     IDLE : first legal non-OFF pattern latches ref_idx -> TRACK, no step.
//            OFF stays IDLE. ILLEGAL -> ERROR.
//     TRACK: legal delta -> step_pulse=1, step_dir/step_half updated, position += +/-1 or +/-2, ref_idx=new_idx.
//            OFF -> IDLE; position is held.
//            ILLEGAL or skip delta -> ERROR, no position change.
//     ERROR: error=1; coil_in is ignored. err_clear -> IDLE next cycle.
//   Simultaneous events:
//     - New error and err_clear in the same cycle: error wins, state stays ERROR.
//     - zero_pos and a step in the same cycle: zero_pos wins (position=0, qturn count=0); step_pulse still fires.
//   Position arithmetic: POS_W-bit two's complement, wraps silently.
//   Quarter-turn counter:
//     - Unsigned, counts half-steps (+1 or +2 per step).
//     - Cleared on direction change (the step that changes direction counts from 0) and on zero_pos.
//     - When count >= QTURN_HALFSTEPS: qturn_pulse=1 and count -= QTURN_HALFSTEPS, so remainders are kept.
//   Reset mid-operation returns to IDLE immediately, with no pulse emitted.
// CONFIGURATION
//   COIL_DEGLITCH_EN defined: a candidate pattern is accepted only after DEGLITCH_CYCLES consecutive identical
//     coil_q samples. Shorter glitches are ignored entirely; they cause no error and no step.
//   COIL_DEGLITCH_EN undefined: every coil_q change is decoded on the next edge. The filter logic is absent.
// STRUCTURE
//   stepper_pkg holds:
//     - phase LUT constants
//     - coil_class_t (OFF/LEGAL/ILLEGAL)
//     - decoder state enum (IDLE/TRACK/ERROR)
//     - function coil_to_phase(), returning index and class
//   Sub-module coil_deglitch (stable-count filter, instantiated only under COIL_DEGLITCH_EN).
//   The FSM and counters live in the top module.
// TESTING
//   1. Reset, then coil_in 0001,0011,0010 (each held 4 clk) -> 2 step_pulses, dir=1, half=1, position=2.
//   2. From TRACK at 0001, apply 1000 then 0100 -> reverse full steps, position -= 2 twice, step_half=0.
//   3. At 0001 jump to 0100 (delta 4) -> error=1 next decode edge, position unchanged.
//      err_clear -> idle=1; 0010 -> TRACK with no pulse.
//   4. QTURN_HALFSTEPS=4: 5 forward half-steps -> qturn_pulse once, on the 4th.
//      Then 1 reverse step -> count resets to 1, no pulse.
//   5. zero_pos coincident with a forward step at position 7 -> position=0, step_pulse=1.
//      Also: pattern 0101 -> ERROR; err_clear in the same cycle as 0111 -> stays ERROR.
//   6. COIL_DEGLITCH_EN, DEGLITCH_CYCLES=3: 2-cycle glitch 0011 inside 0001 -> no pulse.
//      A 3-cycle hold is accepted with latency 2+3 edges.

Source files
------------

// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - coil phase table, pattern classes, decoder states and the pattern-to-phase lookup
package stepper_pkg;

   // Phase index i occupies bits [4*i +: 4]; index 0 is 0001, index 7 is 1001.
   localparam logic [31:0] PHASE_LUT = {4'b1001, 4'b1000, 4'b1100, 4'b0100,
                                        4'b0110, 4'b0010, 4'b0011, 4'b0001};

   typedef enum logic [1:0] {
      COIL_OFF     = 2'd0,
      COIL_LEGAL   = 2'd1,
      COIL_ILLEGAL = 2'd2
   } coil_class_t;

   typedef logic [1:0] dec_state_t;
   localparam dec_state_t ST_IDLE  = 2'd0;
   localparam dec_state_t ST_TRACK = 2'd1;
   localparam dec_state_t ST_ERROR = 2'd2;

   typedef struct packed {
      coil_class_t cls;
      logic [2:0]  idx;
   } coil_phase_t;

   // Classify a coil pattern; idx is only meaningful when cls is COIL_LEGAL.
   function automatic coil_phase_t coil_to_phase(input logic [3:0] code);
      coil_phase_t r;
      r.cls = (code == 4'b0000) ? COIL_OFF : COIL_ILLEGAL;
      r.idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (PHASE_LUT[i*4 +: 4] == code) begin
            r.cls = COIL_LEGAL;
            r.idx = 3'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/coil_deglitch.sv
// rtl/coil_deglitch.sv - stable-count filter for the registered coil pattern (used only with COIL_DEGLITCH_EN)
module coil_deglitch
   import stepper_pkg::*;
#(
   parameter int DEGLITCH_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] coil_q,
   output logic [3:0] coil_stable
);

   localparam int CW = $clog2(DEGLITCH_CYCLES + 1);

   logic [3:0]    cand;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   // Run length of the current candidate, saturating at the acceptance threshold.
   always_comb begin
      cnt_nxt = CW'(1);
      if (coil_q == cand) begin
         cnt_nxt = (cnt == CW'(DEGLITCH_CYCLES)) ? cnt : cnt + CW'(1);
      end
   end

   // Track the candidate and publish it once it has been seen enough times in a row.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand        <= 4'b0000;
         cnt         <= CW'(DEGLITCH_CYCLES);
         coil_stable <= 4'b0000;
      end else begin
         cand <= coil_q;
         cnt  <= cnt_nxt;
         if (cnt_nxt == CW'(DEGLITCH_CYCLES)) begin
            coil_stable <= coil_q;
         end
      end
   end

endmodule

// File: rtl/coil_phase_decoder.sv
// rtl/coil_phase_decoder.sv - stepper coil bus decoder: FSM, position and quarter-turn counters; COIL_DEGLITCH_EN adds an input filter
module coil_phase_decoder
   import stepper_pkg::*;
#(
   parameter int POS_W           = 16,
   parameter int QTURN_HALFSTEPS = 400
`ifdef COIL_DEGLITCH_EN
   ,
   parameter int DEGLITCH_CYCLES = 3
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       coil_in,
   input  logic             zero_pos,
   input  logic             err_clear,
   output logic             step_pulse,
   output logic             step_dir,
   output logic             step_half,
   output logic [POS_W-1:0] position,
   output logic             qturn_pulse,
   output logic             idle,
   output logic             error
);

   // Count can momentarily reach QTURN_HALFSTEPS+1 before the wrap subtraction.
   localparam int QCW = $clog2(QTURN_HALFSTEPS + 2);

   logic [3:0]    coil_q;
   logic [3:0]    coil_dec;
   coil_phase_t   ph;
   logic [2:0]    delta;

   dec_state_t    state, st_n;
   logic [2:0]    ref_idx, ref_n;
   logic [QCW-1:0] qcnt, q_n, qsum;
   logic [POS_W-1:0] pos_n;
   logic          pulse_n, dir_n, half_n, qt_n;
   logic          step_ev, fwd;
   logic [1:0]    amt;

   // Register the asynchronous-looking drive bus once before decoding.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) coil_q <= 4'b0000;
      else     coil_q <= coil_in;
   end

`ifdef COIL_DEGLITCH_EN
   coil_deglitch #(
      .DEGLITCH_CYCLES (DEGLITCH_CYCLES)
   ) u_deglitch (
      .clk         (clk),
      .rst         (rst),
      .coil_q      (coil_q),
      .coil_stable (coil_dec)
   );
`else
   assign coil_dec = coil_q;
`endif

   assign ph    = coil_to_phase(coil_dec);
   assign delta = ph.idx - ref_idx;
   assign idle  = (state == ST_IDLE);
   assign error = (state == ST_ERROR);

   // Next-state decode: classify the phase move, then apply step and zeroing side effects.
   always_comb begin
      st_n    = state;
      ref_n   = ref_idx;
      pos_n   = position;
      q_n     = qcnt;
      qsum    = '0;
      pulse_n = 1'b0;
      dir_n   = step_dir;
      half_n  = step_half;
      qt_n    = 1'b0;
      step_ev = 1'b0;
      fwd     = 1'b0;
      amt     = 2'd0;
      case (state)
         ST_IDLE: begin
            if (ph.cls == COIL_ILLEGAL) begin
               st_n = ST_ERROR;
            end else if (ph.cls == COIL_LEGAL) begin
               ref_n = ph.idx;
               st_n  = ST_TRACK;
            end
         end
         ST_TRACK: begin
            if (ph.cls == COIL_OFF) begin
               st_n = ST_IDLE;
            end else if (ph.cls == COIL_ILLEGAL) begin
               st_n = ST_ERROR;
            end else begin
               case (delta)
                  3'd0: ;
                  3'd1: begin step_ev = 1'b1; fwd = 1'b1; amt = 2'd1; end
                  3'd2: begin step_ev = 1'b1; fwd = 1'b1; amt = 2'd2; end
                  3'd7: begin step_ev = 1'b1; fwd = 1'b0; amt = 2'd1; end
                  3'd6: begin step_ev = 1'b1; fwd = 1'b0; amt = 2'd2; end
                  default: st_n = ST_ERROR;
               endcase
            end
         end
         ST_ERROR: begin
            // A pattern that is itself illegal keeps us in ERROR even if a clear arrives.
            if (err_clear && (ph.cls != COIL_ILLEGAL)) st_n = ST_IDLE;
         end
         default: st_n = ST_IDLE;
      endcase

      if (step_ev) begin
         pulse_n = 1'b1;
         dir_n   = fwd;
         half_n  = (amt == 2'd1);
         ref_n   = ph.idx;
         pos_n   = fwd ? position + POS_W'(amt) : position - POS_W'(amt);
         qsum    = ((fwd != step_dir) ? '0 : qcnt) + QCW'(amt);
         if (qsum >= QCW'(QTURN_HALFSTEPS)) begin
            qt_n = 1'b1;
            q_n  = qsum - QCW'(QTURN_HALFSTEPS);
         end else begin
            q_n  = qsum;
         end
      end

      if (zero_pos) begin
         pos_n = '0;
         q_n   = '0;
         qt_n  = 1'b0;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         ref_idx     <= 3'd0;
         qcnt        <= '0;
         position    <= '0;
         step_pulse  <= 1'b0;
         step_dir    <= 1'b0;
         step_half   <= 1'b0;
         qturn_pulse <= 1'b0;
      end else begin
         state       <= st_n;
         ref_idx     <= ref_n;
         qcnt        <= q_n;
         position    <= pos_n;
         step_pulse  <= pulse_n;
         step_dir    <= dir_n;
         step_half   <= half_n;
         qturn_pulse <= qt_n;
      end
   end

endmodule

// File: tb/tb_coil_phase_decoder.sv
// tb/tb_coil_phase_decoder.sv - randomized scoreboard bench for coil_phase_decoder
module tb_coil_phase_decoder;

   localparam int POS_W = 8;
   localparam int QT    = 4;
`ifdef COIL_DEGLITCH_EN
   localparam int DEG   = 3;
   localparam int LAT   = 2 + DEG;
`else
   localparam int LAT   = 2;
`endif
   localparam int HOLD  = LAT + 5;

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       coil_in;
   logic             zero_pos;
   logic             err_clear;
   logic             step_pulse, step_dir, step_half, qturn_pulse, idle, error;
   logic [POS_W-1:0] position;

   always #5 clk = ~clk;

   coil_phase_decoder #(
      .POS_W           (POS_W),
      .QTURN_HALFSTEPS (QT)
`ifdef COIL_DEGLITCH_EN
      ,
      .DEGLITCH_CYCLES (DEG)
`endif
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .coil_in     (coil_in),
      .zero_pos    (zero_pos),
      .err_clear   (err_clear),
      .step_pulse  (step_pulse),
      .step_dir    (step_dir),
      .step_half   (step_half),
      .position    (position),
      .qturn_pulse (qturn_pulse),
      .idle        (idle),
      .error       (error)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit dir;
      bit half;
      int pos;
      bit qt;
   } ev_t;
   ev_t evq[$];
   ev_t mon_e;

   int codes[8] = '{1, 3, 2, 6, 4, 12, 8, 9};
   int ill[7]   = '{5, 7, 10, 11, 13, 14, 15};

   // Reference model: mode 0 idle, 1 track, 2 error; position kept unbounded.
   int m_mode, m_ref, m_pos, m_q;
   bit m_dir, m_half;
   int cur_code;
   int last_lat;

   function automatic int phase_of(int code);
      if (code == 0) return -1;
      for (int i = 0; i < 8; i++) if (codes[i] == code) return i;
      return -2;
   endfunction

   function automatic int wrapp(int p);
      return p & ((1 << POS_W) - 1);
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic model_apply(int code, bit zero);
      int p, d, amt;
      bit fwd, stepped, qt;
      ev_t e;
      p = phase_of(code);
      stepped = 0;
      qt = 0;
      if (m_mode == 0) begin
         if (p == -2) m_mode = 2;
         else if (p >= 0) begin m_ref = p; m_mode = 1; end
      end else if (m_mode == 1) begin
         if (p == -1) m_mode = 0;
         else if (p == -2) m_mode = 2;
         else begin
            d = (p - m_ref + 8) % 8;
            if (d == 1 || d == 2 || d == 6 || d == 7) begin
               fwd = (d <= 2);
               amt = (d == 1 || d == 7) ? 1 : 2;
               stepped = 1;
               if (fwd != m_dir) m_q = 0;
               m_dir  = fwd;
               m_half = (amt == 1);
               m_ref  = p;
               m_pos  = fwd ? m_pos + amt : m_pos - amt;
               m_q    = m_q + amt;
               if (m_q >= QT) begin qt = 1; m_q = m_q - QT; end
            end else if (d != 0) begin
               m_mode = 2;
            end
         end
      end
      if (zero) begin m_pos = 0; m_q = 0; qt = 0; end
      if (stepped) begin
         e.dir = m_dir; e.half = m_half; e.pos = wrapp(m_pos); e.qt = qt;
         evq.push_back(e);
      end
   endtask

   task automatic settle_check(string tag);
      chk({tag, "_idle"},  int'(idle),      (m_mode == 0) ? 1 : 0);
      chk({tag, "_error"}, int'(error),     (m_mode == 2) ? 1 : 0);
      chk({tag, "_pos"},   int'(position),  wrapp(m_pos));
      chk({tag, "_dir"},   int'(step_dir),  int'(m_dir));
      chk({tag, "_half"},  int'(step_half), int'(m_half));
   endtask

   // Drive one pattern for n cycles; optionally strobe zero_pos on the decode edge.
   task automatic hold(int code, int n, bit zero_at_decode, string tag);
      int seen;
      seen = 0;
      cur_code = code;
      coil_in = 4'(code);
      model_apply(code, zero_at_decode);
      for (int i = 1; i <= n; i++) begin
         if (zero_at_decode && i == LAT) zero_pos = 1'b1;
         @(posedge clk); #1;
         zero_pos = 1'b0;
         if (step_pulse && seen == 0) seen = i;
      end
      last_lat = seen;
      settle_check(tag);
   endtask

   task automatic clear_err(string tag);
      err_clear = 1'b1;
      @(posedge clk); #1;
      err_clear = 1'b0;
      if (m_mode == 2 && phase_of(cur_code) != -2) begin
         m_mode = 0;
         chk({tag, "_idle_after_clear"}, int'(idle), 1);
         model_apply(cur_code, 0);
      end else begin
         chk({tag, "_error_held"}, int'(error), (m_mode == 2) ? 1 : 0);
      end
      repeat (3) @(posedge clk);
      #1;
      settle_check(tag);
   endtask

   task automatic zero_only(string tag);
      zero_pos = 1'b1;
      @(posedge clk); #1;
      zero_pos = 1'b0;
      m_pos = 0;
      m_q = 0;
      chk({tag, "_pos"}, int'(position), 0);
   endtask

   // Monitor: every step pulse must match the oldest expected event.
   always @(negedge clk) begin
      if (!rst) begin
         if (step_pulse) begin
            if (evq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_step actual=1 expected=0 pos=%0d", position);
            end else begin
               mon_e = evq.pop_front();
               chk("ev_dir",  int'(step_dir),    int'(mon_e.dir));
               chk("ev_half", int'(step_half),   int'(mon_e.half));
               chk("ev_pos",  int'(position),    mon_e.pos);
               chk("ev_qt",   int'(qturn_pulse), int'(mon_e.qt));
            end
         end else if (qturn_pulse) begin
            checks++;
            failures++;
            $display("FAIL qturn_without_step actual=1 expected=0");
         end
      end
   end

   initial begin
      int r, c;
      int steps4[4] = '{1, 2, 6, 7};
      rst = 1'b1; coil_in = 4'd0; zero_pos = 1'b0; err_clear = 1'b0;
      m_mode = 0; m_ref = 0; m_pos = 0; m_q = 0; m_dir = 0; m_half = 0;
      cur_code = 0; last_lat = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_idle",  int'(idle), 1);
      chk("rst_error", int'(error), 0);
      chk("rst_step",  int'(step_pulse), 0);
      chk("rst_qturn", int'(qturn_pulse), 0);
      chk("rst_pos",   int'(position), 0);
      chk("rst_dir",   int'(step_dir), 0);
      chk("rst_half",  int'(step_half), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Forward half-steps from the first reference.
      hold(4'b0001, HOLD, 0, "t1a");
      hold(4'b0011, HOLD, 0, "t1b");
      chk("t1_latency", last_lat, LAT);
      hold(4'b0010, HOLD, 0, "t1c");
      chk("t1_pos", int'(position), 2);

      // Reverse full steps.
      hold(4'b0001, HOLD, 0, "t2a");
      hold(4'b1000, HOLD, 0, "t2b");
      hold(4'b0100, HOLD, 0, "t2c");
      chk("t2_pos", int'(position), wrapp(-4));
      chk("t2_half", int'(step_half), 0);

      // Skip error, clear, relatch without a pulse.
      hold(4'b0110, HOLD, 0, "t3a");
      hold(4'b0010, HOLD, 0, "t3b");
      hold(4'b0011, HOLD, 0, "t3c");
      hold(4'b0001, HOLD, 0, "t3d");
      hold(4'b0100, HOLD, 0, "t3e");
      chk("t3_error", int'(error), 1);
      hold(4'b0010, HOLD, 0, "t3f");
      clear_err("t3g");
      hold(4'b0011, HOLD, 0, "t3h");

      // Quarter-turn accounting.
      zero_only("t4z");
      for (int k = 0; k < 5; k++) hold(codes[(m_ref + 1) % 8], HOLD, 0, "t4f");
      hold(codes[(m_ref + 7) % 8], HOLD, 0, "t4r");

      // zero_pos coincident with a step, then illegal patterns and blocked clear.
      zero_only("t5z");
      for (int k = 0; k < 7; k++) hold(codes[(m_ref + 1) % 8], HOLD, 0, "t5f");
      chk("t5_pos7", int'(position), 7);
      hold(codes[(m_ref + 1) % 8], HOLD, 1, "t5zs");
      chk("t5_zero_step_pos", int'(position), 0);
      hold(4'b0101, HOLD, 0, "t5i");
      hold(4'b0111, HOLD, 0, "t5j");
      clear_err("t5k");
      hold(4'b0001, HOLD, 0, "t5l");
      clear_err("t5m");

`ifdef COIL_DEGLITCH_EN
      // Two-cycle glitch must be swallowed.
      c = cur_code;
      coil_in = 4'(codes[(m_ref + 1) % 8]);
      repeat (2) @(posedge clk);
      #1;
      coil_in = 4'(c);
      repeat (HOLD) @(posedge clk);
      #1;
      settle_check("t6_glitch");
`endif

      // Long forward run wraps the narrow position counter.
      for (int k = 0; k < 70; k++) hold(codes[(m_ref + 2) % 8], HOLD, 0, "wrap");

      // Asynchronous reset in the middle of a cycle.
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_idle", int'(idle), 1);
      chk("mid_rst_pos",  int'(position), 0);
      chk("mid_rst_step", int'(step_pulse), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      m_mode = 0; m_pos = 0; m_q = 0; m_dir = 0; m_half = 0;
      model_apply(cur_code, 0);
      repeat (HOLD) @(posedge clk);
      #1;
      settle_check("mid_rst");

      // Randomized walk.
      for (int k = 0; k < 300; k++) begin
         r = $urandom_range(0, 99);
         if (m_mode == 2) begin
            if (r < 30) hold($urandom_range(0, 15), HOLD, 0, "rnd_e");
            clear_err("rnd_c");
         end else if (r < 70) begin
            c = codes[(m_ref + steps4[$urandom_range(0, 3)]) % 8];
            hold(c, HOLD, ($urandom_range(0, 9) == 0), "rnd_s");
         end else if (r < 78) begin
            hold(0, HOLD, 0, "rnd_off");
         end else if (r < 86) begin
            hold(ill[$urandom_range(0, 6)], HOLD, 0, "rnd_ill");
         end else if (r < 94) begin
            hold(codes[(m_ref + $urandom_range(3, 5)) % 8], HOLD, 0, "rnd_skip");
         end else begin
            zero_only("rnd_z");
         end
      end

      repeat (4) @(posedge clk);
      #1;
      chk("queue_empty", evq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
